// File: rtl/if_seg.sv
// if_seg -- instruction-fetch segment.
// Keeps the PC, fetches one word at a time over a split request/response
// memory interface, buffers returned words in a 2-entry prefetch queue and
// drives the IF/ID pipeline register consumed by decode.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   stall               decode cannot accept; IF/ID holds, queue does not pop
//   redirect/redirect_pc taken branch/jump: flush everything, restart fetch
//   imem_req/imem_addr  address phase, held stable until imem_gnt
//   imem_gnt            memory accepts the address this cycle
//   imem_rvalid/rdata   response for the single outstanding request
//   NPCo/IRo/valid      IF/ID register (valid=0 marks a bubble)
module if_seg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_IR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] NPCo,
  output logic [31:0] IRo,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] ir;
  } ent_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tag_q, tag_d;
  ent_t [1:0]  q_q, q_d;      // entry 0 is the head
  logic [1:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] ir_q, ir_d;
  logic        vld_q, vld_d;

  logic fire, push, pop;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tag_d   = tag_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    npc_d   = npc_q;
    ir_d    = ir_q;
    vld_d   = vld_q;
    push    = 1'b0;
    fire    = (state_q == IDLE) && req_q && imem_gnt;
    pop     = !stall && (cnt_q != 2'd0);

    case (state_q)
      IDLE: if (fire) begin
        pc_d    = pc_q + 32'd4;
        tag_d   = pc_q;
        state_d = WAIT;
      end
      WAIT: if (imem_rvalid) begin
        push    = 1'b1;
        state_d = IDLE;
      end
      DROP: if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pop before push: a word arriving into an empty queue always lands in
    // the queue first, never straight into IF/ID.
    if (pop) begin
      npc_d  = q_q[0].npc;
      ir_d   = q_q[0].ir;
      vld_d  = 1'b1;
      q_d[0] = q_q[1];
      cnt_d  = cnt_q - 2'd1;
    end else if (!stall) begin
      npc_d = 32'd0;
      ir_d  = NOP_IR;
      vld_d = 1'b0;
    end

    // Room was reserved when the request issued, so cnt_d is 0 or 1 here.
    if (push) begin
      q_d[cnt_d[0]].npc = tag_q + 32'd4;
      q_d[cnt_d[0]].ir  = imem_rdata;
      cnt_d             = cnt_d + 2'd1;
    end

    if (redirect) begin
      cnt_d = 2'd0;
      npc_d = 32'd0;
      ir_d  = NOP_IR;
      vld_d = 1'b0;
      pc_d  = redirect_pc;
      // Drop only if a response is still owed after this cycle: a grant now,
      // or a WAIT/DROP whose response is not arriving this very cycle.
      // Otherwise nothing would ever arrive to leave DROP.
      if (fire || ((state_q == WAIT || state_q == DROP) && !imem_rvalid))
        state_d = DROP;
      else
        state_d = IDLE;
    end

    req_d = (state_d == IDLE) && (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tag_q   <= RESET_PC;
      q_q     <= '0;
      cnt_q   <= 2'd0;
      req_q   <= 1'b0;
      npc_q   <= 32'd0;
      ir_q    <= NOP_IR;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tag_q   <= tag_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
      vld_q   <= vld_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign NPCo      = npc_q;
  assign IRo       = ir_q;
  assign valid     = vld_q;

endmodule

// File: tb/tb_if_seg.sv
// Bench for if_seg: a memory model with random grant/latency, and a
// program-order scoreboard (next expected NPC, word = mem_word(NPC-4)).
module tb_if_seg;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, valid;
  logic [31:0] imem_addr, NPCo, IRo;

  if_seg #(.RESET_PC(RST_PC), .NOP_IR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .NPCo(NPCo), .IRo(IRo), .valid(valid)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0020;
  endfunction

  // memory model
  bit          pend = 0, poison = 0;
  int          pend_cnt = 0, rv_count = 0;
  logic [31:0] pend_addr = '0;
  int          gnt_pct = 100, lat_min = 1, lat_max = 1;

  // scoreboard
  logic [31:0] exp_npc = RST_PC + 32'd4, hold_npc = '0, hold_ir = NOP;
  logic        hold_vld = 1'b0;
  bit          p_redir = 0, p_stall = 0, p_req = 0, p_gnt = 0;
  logic [31:0] p_addr = '0;
  int          vld_count = 0;

  task automatic observe();
    if (p_req && !p_gnt && !p_redir) begin
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, p_addr);
    end
    if (p_redir) begin
      chk("redir_vld", valid, 0);
      chk("redir_ir", IRo, NOP);
      chk("redir_npc", NPCo, 0);
    end else if (p_stall) begin
      chk("stall_vld", valid, hold_vld);
      chk("stall_ir", IRo, hold_ir);
      chk("stall_npc", NPCo, hold_npc);
    end else if (valid) begin
      chk("npc_seq", NPCo, exp_npc);
      chk("ir_data", IRo, mem_word(NPCo - 32'd4));
      exp_npc += 32'd4;
      vld_count++;
    end else begin
      chk("bub_ir", IRo, NOP);
      chk("bub_npc", NPCo, 0);
    end
    hold_vld = valid; hold_ir = IRo; hold_npc = NPCo;
  endtask

  // Called at a negedge with stall/redirect already set by the caller.
  task automatic tick();
    imem_rvalid = 1'b0; imem_rdata = '0; imem_gnt = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = poison ? 32'hDEAD_BEEF : mem_word(pend_addr);
        poison = 0; pend = 0; rv_count++;
      end else pend_cnt--;
    end
    if (imem_req) begin
      chk("one_outstanding", {31'd0, pend}, 0);
      if (!pend && int'($urandom_range(99)) < gnt_pct) begin
        imem_gnt = 1'b1; pend = 1; pend_addr = imem_addr;
        pend_cnt = int'($urandom_range(lat_max, lat_min)) - 1;
      end
    end
    p_req = imem_req; p_addr = imem_addr; p_gnt = imem_gnt;
    p_redir = redirect; p_stall = stall;
    if (redirect) exp_npc = redirect_pc + 32'd4;
    @(posedge clk);
    @(negedge clk);
    observe();
  endtask

  task automatic rst_vals();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_npc", NPCo, 0);
    chk("rst_ir", IRo, NOP);
    chk("rst_vld", valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    stall = 1'b0; redirect = 1'b0; pend = 0; poison = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_npc = RST_PC + 32'd4;
    p_req = 0; p_redir = 0; p_stall = 0; p_gnt = 0;
    hold_vld = 1'b0; hold_ir = NOP; hold_npc = '0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (valid) begin ok = 1; return; end
    end
  endtask

  task automatic wait_gnt(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (p_gnt) begin ok = 1; return; end
    end
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (imem_req) begin ok = 1; return; end
    end
  endtask

  initial begin
    bit ok;
    #1 rst_vals();
    do_reset();

    // first fetch and latency
    tick();
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 32'h0);
    tick();                     // granted
    tick();                     // rvalid: word goes to the queue
    chk("t1_notyet", valid, 0);
    chk("t1_req4", imem_req, 1);
    chk("t1_addr4", imem_addr, 32'h4);
    tick();
    chk("t1_ir", IRo, 32'h0000_0020);
    chk("t1_npc", NPCo, 32'h4);
    chk("t1_vld", valid, 1);

    // stall 10 cycles: exactly two more words queued, then requests stop
    stall = 1'b1; rv_count = 0;
    repeat (10) tick();
    chk("t2_rv", rv_count, 2);
    chk("t2_req", imem_req, 0);
    chk("t2_ir_hold", IRo, 32'h0000_0020);
    stall = 1'b0;
    tick();
    chk("t2_npc8", NPCo, 32'h8);
    chk("t2_vld8", valid, 1);
    tick();
    chk("t2_npc12", NPCo, 32'hC);

    // redirect while in WAIT; stale response returns DEAD_BEEF later
    lat_min = 3; lat_max = 3;
    wait_gnt(20, ok);
    chk("t3_gnt_seen", ok, 1);
    poison = 1; redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    chk("t3_bubble", valid, 0);
    wait_req(20, ok);
    chk("t3_req_seen", ok, 1);
    chk("t3_addr", imem_addr, 32'h100);
    wait_valid(30, ok);
    chk("t3_vld_seen", ok, 1);
    chk("t3_npc", NPCo, 32'h104);
    chk("t3_no_stale", {31'd0, IRo == 32'hDEAD_BEEF}, 0);

    // redirect + stall with a full queue
    lat_min = 1; lat_max = 1;
    stall = 1'b1;
    repeat (12) tick();
    chk("t4_full", imem_req, 0);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    chk("t4_vld", valid, 0);
    chk("t4_ir", IRo, NOP);
    chk("t4_npc", NPCo, 0);
    stall = 1'b0;
    wait_valid(20, ok);
    chk("t4_npc_new", NPCo, 32'h204);

    // wrap-around at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    wait_valid(20, ok);
    chk("t5_vld_seen", ok, 1);
    chk("t5_npc", NPCo, 32'h0);
    chk("t5_ir", IRo, mem_word(32'hFFFF_FFFC));
    wait_valid(20, ok);
    chk("t5_next", NPCo, 32'h4);

    // async reset in the middle of WAIT
    lat_min = 3; lat_max = 3;
    wait_gnt(20, ok);
    chk("t6_gnt_seen", ok, 1);
    #2 rst = 1'b0;
    #1 rst_vals();
    do_reset();
    lat_min = 1; lat_max = 1;
    wait_req(10, ok);
    chk("t6_req_seen", ok, 1);
    chk("t6_addr", imem_addr, RST_PC);

    // random traffic against the scoreboard
    gnt_pct = 70; lat_min = 1; lat_max = 3; vld_count = 0;
    for (int i = 0; i < 1500; i++) begin
      stall    = ($urandom_range(99) < 30);
      redirect = ($urandom_range(99) < 4);
      redirect_pc = ($urandom_range(3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      tick();
    end
    stall = 1'b0; redirect = 1'b0;
    chk("liveness", {31'd0, vld_count > 50}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_seg.md
Name: if_seg

Overview:
- Instruction-fetch stage of the R/I/J pipelined CPU; producer of the NPC/IR pair consumed by the decode segment.
- Keeps the PC and issues word fetches to the instruction memory over a split request/response interface.
- Buffers returned words in a 2-entry prefetch queue and drives the IF/ID pipeline register, honouring decode stall and EX-stage redirect (branch/jump).

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_IR, 32'h0000_0000, instruction word driven on IRo for a bubble

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset
stall  input  1  decode cannot accept; IF/ID register holds
redirect  input  1  branch/jump taken; flush and restart fetch
redirect_pc  input  32  new fetch address, valid with redirect
imem_req  output  1  fetch request (address phase)
imem_addr  output  32  fetch word address, stable while imem_req && !imem_gnt
imem_gnt  input  1  memory accepts address this cycle
imem_rvalid  input  1  read data for oldest accepted request
imem_rdata  input  32  instruction word, valid with imem_rvalid
NPCo  output  32  fetch address + 4 of IRo
IRo  output  32  instruction to decode
valid  output  1  IRo/NPCo hold a real instruction (0 = bubble)

Behaviour:
- Reset (rst low, async): PC=RESET_PC; queue empty; FSM=IDLE; imem_req=0; imem_addr=RESET_PC; NPCo=0; IRo=NOP_IR; valid=0.
- At most one request is outstanding; each request completes with exactly one imem_rvalid, at least 1 cycle after the grant.
- FSM states:
  - IDLE: imem_req=1 when queue count < 2. On imem_gnt: PC<=PC+4, record tag address, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid: push {tag+4, imem_rdata} into the queue, go to IDLE.
  - DROP: imem_req=0. On imem_rvalid: discard the data, go to IDLE.
- Room rule: IDLE issues only when (count + 0) < 2. WAIT entry therefore guarantees a free slot for the response.
- IF/ID register, when !stall:
  - Queue non-empty: load head {NPC, IR}, valid=1, pop.
  - Queue empty: load NPCo=0, IRo=NOP_IR, valid=0.
  - Same-cycle push and pop on an empty queue: the pushed word goes to the queue, not to IF/ID. Fetch-to-IRo latency is therefore 1 cycle after rvalid.
- When stall: IF/ID holds and there is no pop. Pushes continue until the queue is full (count 2). IDLE then stops requesting.
- Redirect (highest priority, overrides stall):
  - Queue cleared; IF/ID loads bubble (valid=0, IRo=NOP_IR, NPCo=0); PC<=redirect_pc.
  - If in WAIT, or in IDLE with imem_gnt in that cycle: FSM->DROP.
  - A grant in the redirect cycle is for the old PC and is dropped.
  - Any rvalid in the redirect cycle is discarded.
  - First new request is issued the cycle after redirect (IDLE) or after the drop response (DROP).
- Redirect while in DROP: stays in DROP, PC updated to the newest redirect_pc.
- PC arithmetic is modulo 2^32: fetch at 32'hFFFF_FFFC gives NPC 32'h0000_0000 and next PC 0. Low 2 bits of redirect_pc are passed through unchanged.
- imem_req is held with a stable imem_addr until granted. Deassertion without a grant is allowed only on redirect.

Test Plan:
- Reset then release, memory with gnt=1 and rvalid 1 cycle later returning 32'h0000_0020 at addr 0 -> imem_addr 0; IRo=32'h0000_0020, NPCo=4, valid=1 one cycle after rvalid; next request is addr 4.
- Stall held 10 cycles from a steady stream -> IRo/NPCo constant; exactly 2 further responses queued, then imem_req=0. On stall release, queued words appear on consecutive cycles with NPCo 8, then 12.
- Redirect to 32'h0000_0100 while in WAIT, stale response 32'hDEAD_BEEF arriving 2 cycles later -> DEAD_BEEF never seen on IRo; bubble (valid=0) after redirect; next imem_addr=32'h100; later NPCo=32'h104.
- Redirect and stall asserted in the same cycle with a full queue -> queue flushed, IRo=NOP_IR, valid=0 despite stall.
- Redirect to 32'hFFFF_FFFC -> NPCo=32'h0000_0000 for that word; following fetch address is 0.
- Assert rst low mid-WAIT asynchronously -> outputs immediately at reset values. After release, the first request is to RESET_PC and the late rvalid from before reset is not required to be handled; the bench holds memory quiet during reset.
